// File: rtl/fifo_readout_display.sv
// Read side of the UART FIFO: debounced RD button pops one byte per press,
// shows it on LED and as hex on a 4-digit seven-segment display with a pop count.
module fifo_readout_display #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int REFRESH_CYCLES  = 100000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       RD,
  input  logic       fifo_empty,
  input  logic [7:0] fifo_dout,
  output logic       fifo_rd_en,
  output logic       byte_valid,
  output logic [7:0] LED,
  output logic       err_LED,
  output logic [6:0] seg,
  output logic [3:0] an
);

  localparam int DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int RW = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] POP     = 2'd1;
  localparam logic [1:0] WAIT    = 2'd2;
  localparam logic [1:0] CAPTURE = 2'd3;

  logic          sync1, sync2;
  logic          debounced, debounced_d;
  logic [DW-1:0] db_cnt;
  logic          rd_pulse;
  logic [1:0]    state;
  logic [7:0]    pop_count;
  logic [RW-1:0] ref_cnt;
  logic [1:0]    sel, sel_next;
  logic [3:0]    nib;

  function automatic logic [6:0] hex7(input logic [3:0] v);
    case (v)
      4'h0: hex7 = 7'h40;
      4'h1: hex7 = 7'h79;
      4'h2: hex7 = 7'h24;
      4'h3: hex7 = 7'h30;
      4'h4: hex7 = 7'h19;
      4'h5: hex7 = 7'h12;
      4'h6: hex7 = 7'h02;
      4'h7: hex7 = 7'h78;
      4'h8: hex7 = 7'h00;
      4'h9: hex7 = 7'h10;
      4'hA: hex7 = 7'h08;
      4'hB: hex7 = 7'h03;
      4'hC: hex7 = 7'h46;
      4'hD: hex7 = 7'h21;
      4'hE: hex7 = 7'h06;
      default: hex7 = 7'h0E;
    endcase
  endfunction

  // Button conditioning: 2-flop synchroniser, debounce, rising-edge pulse
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1       <= 1'b0;
      sync2       <= 1'b0;
      debounced   <= 1'b0;
      debounced_d <= 1'b0;
      db_cnt      <= '0;
      rd_pulse    <= 1'b0;
    end else begin
      sync1       <= RD;
      sync2       <= sync1;
      debounced_d <= debounced;
      rd_pulse    <= debounced & ~debounced_d;
      if (sync2 != debounced) begin
        if (db_cnt == DW'(DEBOUNCE_CYCLES - 1)) begin
          debounced <= ~debounced;
          db_cnt    <= '0;
        end else begin
          db_cnt <= db_cnt + 1'b1;
        end
      end else begin
        db_cnt <= '0;
      end
    end
  end

  // Pop sequencer; presses arriving outside IDLE are dropped
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      LED       <= 8'h00;
      err_LED   <= 1'b0;
      pop_count <= 8'h00;
    end else begin
      case (state)
        IDLE: begin
          if (rd_pulse) begin
            if (fifo_empty) err_LED <= 1'b1;
            else            state   <= POP;
          end
        end
        POP:  state <= WAIT;
        WAIT: begin
          LED       <= fifo_dout;
          pop_count <= pop_count + 8'd1;
          err_LED   <= 1'b0;
          state     <= CAPTURE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign fifo_rd_en = (state == POP);
  assign byte_valid = (state == CAPTURE);

  always_comb begin
    sel_next = sel;
    if (ref_cnt == RW'(REFRESH_CYCLES - 1)) sel_next = sel + 2'd1;
    case (sel_next)
      2'd0:    nib = LED[3:0];
      2'd1:    nib = LED[7:4];
      2'd2:    nib = pop_count[3:0];
      default: nib = pop_count[7:4];
    endcase
  end

  // an and seg are loaded together from sel_next so they never disagree
  always_ff @(posedge clk) begin
    if (reset) begin
      ref_cnt <= '0;
      sel     <= 2'd0;
      an      <= 4'b1110;
      seg     <= 7'b1000000;
    end else begin
      ref_cnt <= (ref_cnt == RW'(REFRESH_CYCLES - 1)) ? '0 : ref_cnt + 1'b1;
      sel     <= sel_next;
      an      <= ~(4'b0001 << sel_next);
      seg     <= hex7(nib);
    end
  end

endmodule
